// File: rtl/ascon_pkg.sv
// ascon_pkg: shared ASCON constants, FSM states, round-constant and AD padding helpers
package ascon_pkg;
  localparam int STATE_W = 320;
  typedef enum logic [2:0] {IDLE, ABSORB, PERM, PAD, FIN} state_t;
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hf - i, i};
  endfunction
  // data is left-aligned in 128 bits; a pad byte landing past the rate is discarded by the caller
  function automatic logic [127:0] pad_block(input logic [127:0] data, input logic [4:0] nbytes);
    logic [127:0] keep;
    keep = ~({128{1'b1}} >> {nbytes, 3'b000});
    return (data & keep) | ({1'b1, 127'b0} >> {nbytes, 3'b000});
  endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round (constant add, bitsliced S-box, linear layer)
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] s_in,
  input  logic [3:0]         idx,
  output logic [STATE_W-1:0] s_out
);
  logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
  always_comb begin
    x0 = s_in[319:256];
    x1 = s_in[255:192];
    x2 = s_in[191:128] ^ {56'b0, rc(idx)};
    x3 = s_in[127:64];
    x4 = s_in[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    s_out = {x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]},
             x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]},
             x2 ^ {x2[0], x2[63:1]} ^ {x2[5:0], x2[63:6]},
             x3 ^ {x3[9:0], x3[63:10]} ^ {x3[16:0], x3[63:17]},
             x4 ^ {x4[6:0], x4[63:7]} ^ {x4[40:0], x4[63:41]}};
  end
endmodule

// File: rtl/ascon_ad_absorb.sv
// ascon_ad_absorb: streams padded AD blocks into the rate, runs p^b iteratively, applies domain separation
module ascon_ad_absorb
  import ascon_pkg::*;
#(
  parameter int RATE_BITS = 64,
  parameter int PB_ROUNDS = 6,
  parameter int UNROLL    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               ad_empty,
  input  logic [STATE_W-1:0]                 s_in,
  input  logic [RATE_BITS-1:0]               ad_data,
  input  logic                               ad_valid,
  input  logic                               ad_last,
  input  logic [$clog2(RATE_BITS/8+1)-1:0]   ad_bytes,
  output logic                               ad_ready,
  output logic                               busy,
  output logic                               done,
  output logic [STATE_W-1:0]                 s_out
);
  localparam int RB = RATE_BITS / 8;
  localparam int BW = $clog2(RB + 1);
  state_t state, state_n;
  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] chain [UNROLL+1];
  logic [3:0] k;
  logic last, need_pad, done_p, fire, perm_last, full, go;
  logic [127:0] padded;
  logic [RATE_BITS-1:0] blk;
  assign chain[0] = st;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    ascon_round u_round (
      .s_in (chain[j]),
      .idx  (4'(12 - PB_ROUNDS + j) + k),
      .s_out(chain[j+1])
    );
  end
  assign ad_ready  = state == ABSORB;
  assign busy      = state != IDLE || done_p;
  assign go        = state == IDLE && start && !busy;
  assign fire      = ad_ready && ad_valid;
  assign perm_last = k == 4'(PB_ROUNDS - UNROLL);
  assign full      = ad_bytes >= BW'(RB);
  // non-last words pass through by padding at full length, which drops the pad byte past the rate
  assign padded = pad_block(state == PAD ? 128'b0 : 128'(ad_data) << (128 - RATE_BITS),
                            state == PAD ? 5'd0 : (ad_last ? 5'(ad_bytes) : 5'(RB)));
  assign blk = RATE_BITS'(padded >> (128 - RATE_BITS));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? (ad_empty ? FIN : ABSORB) : IDLE;
      ABSORB:  state_n = ad_valid ? PERM : ABSORB;
      PERM:    state_n = !perm_last ? PERM : (!last ? ABSORB : (need_pad ? PAD : FIN));
      PAD:     state_n = PERM;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      st       <= '0;
      s_out    <= '0;
      k        <= '0;
      last     <= 1'b0;
      need_pad <= 1'b0;
      done_p   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_n;
      done_p <= state == FIN;
      done   <= done_p;
      if (go) st <= s_in;
      if (fire || state == PAD) st[STATE_W-1 -: RATE_BITS] <= st[STATE_W-1 -: RATE_BITS] ^ blk;
      if (fire) begin
        last     <= ad_last;
        need_pad <= ad_last && full;
      end
      if (state == PAD) need_pad <= 1'b0;
      if (state == PERM) begin
        st <= chain[UNROLL];
        k  <= perm_last ? 4'd0 : k + 4'(UNROLL);
      end
      if (state == FIN) begin
        st    <= st ^ 320'h1;
        s_out <= st ^ 320'h1;
      end
    end
  end
endmodule
